// File: rtl/grid_writer.sv
// 4x4 board state with a shadow buffer that is committed to the row colour
// buses only at frame boundaries, plus a blinking cursor overlay and a 16-cycle clear sweep.
module grid_writer #(
  parameter logic [11:0] CLEAR_COLOR  = 12'h000,
  parameter logic [11:0] CURSOR_COLOR = 12'hFFF,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_end,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_set,
  input  logic        clear,
  input  logic [11:0] color_in,
  input  logic        error_clr,
  output logic [47:0] x1,
  output logic [47:0] x2,
  output logic [47:0] x3,
  output logic [47:0] x4,
  output logic        error,
  output logic [1:0]  cursor_row,
  output logic [1:0]  cursor_col,
  output logic        busy
);

  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  // state_q is the FSM state; observe it hierarchically when binding checkers.
  state_t                state_q, state_d;
  logic [3:0][3:0][11:0] shadow_q, shadow_d;
  logic [3:0][3:0][11:0] disp_q, disp_d;
  logic [1:0]            row_q, row_d, col_q, col_d;
  logic [3:0]            idx_q, idx_d;
  logic                  err_q, err_d, err_set;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  phase_q, phase_d;
  logic                  pend_q, pend_d;
  logic [5:0]            cmds;
  logic                  cmd_any, cmd_multi;

  assign cmds      = {btn_up, btn_down, btn_left, btn_right, btn_set, clear};
  assign cmd_any   = |cmds;
  assign cmd_multi = |(cmds & (cmds - 6'd1));

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    disp_d   = disp_q;
    row_d    = row_q;
    col_d    = col_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    pend_d   = pend_q;
    err_set  = 1'b0;

    if (frame_end) begin
      pend_d = 1'b1;
      if (cnt_q == CW'(BLINK_FRAMES - 1)) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (cmd_multi) begin
          err_set = 1'b1;
        end else if (btn_up) begin
          if (row_q == 2'd0) err_set = 1'b1;
          else               row_d   = row_q - 2'd1;
        end else if (btn_down) begin
          if (row_q == 2'd3) err_set = 1'b1;
          else               row_d   = row_q + 2'd1;
        end else if (btn_left) begin
          if (col_q == 2'd0) err_set = 1'b1;
          else               col_d   = col_q - 2'd1;
        end else if (btn_right) begin
          if (col_q == 2'd3) err_set = 1'b1;
          else               col_d   = col_q + 2'd1;
        end else if (btn_set) begin
          shadow_d[row_q][col_q] = color_in;
        end else if (clear) begin
          state_d = CLEAR;
          row_d   = 2'd0;
          col_d   = 2'd0;
          idx_d   = 4'd0;
        end
        // Commit uses pre-edge shadow and cursor, but the post-edge blink phase.
        if (frame_end || pend_q) begin
          disp_d = shadow_q;
          if (phase_d) disp_d[row_q][col_q] = CURSOR_COLOR;
          pend_d = 1'b0;
        end
      end
      CLEAR: begin
        if (cmd_any) err_set = 1'b1;
        shadow_d[idx_q[3:2]][idx_q[1:0]] = CLEAR_COLOR;
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (err_set)        err_d = 1'b1;
    else if (error_clr) err_d = 1'b0;
    else                err_d = err_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= {16{CLEAR_COLOR}};
      disp_q   <= {16{CLEAR_COLOR}};
      row_q    <= 2'd0;
      col_q    <= 2'd0;
      idx_q    <= 4'd0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      row_q    <= row_d;
      col_q    <= col_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      pend_q   <= pend_d;
    end
  end

  assign x1         = disp_q[0];
  assign x2         = disp_q[1];
  assign x3         = disp_q[2];
  assign x4         = disp_q[3];
  assign error      = err_q;
  assign cursor_row = row_q;
  assign cursor_col = col_q;
  assign busy       = (state_q == CLEAR);

endmodule
